// File: rtl/matbi_watch_ctrl.sv
// rtl/matbi_watch_ctrl.sv - run/pause/set controller and HH:MM:SS timekeeper
//
// Purpose: sequences the watch between IDLE, RUN, PAUSE and SET, drives the
// one-second tick generator (run enable, latched divide value, sync restart)
// and keeps the HH:MM:SS time. It counts the generator's 1-cycle tick.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_start/i_stop    run-control command pulses
//   i_clear           zero the time and return to IDLE
//   i_set_en          enter SET (from IDLE or PAUSE)
//   i_set_valid       load i_set_hour/min/sec while in SET
//   i_freq_cfg        clocks per second requested for the next fresh start
//   i_one_sec_tick    1-cycle tick from the generator
//   o_run_en          generator run enable (state == RUN)
//   o_freq            latched generator divide value
//   o_gen_reset       1-cycle generator restart
//   o_hour/min/sec    current time
//   o_state           0=IDLE 1=RUN 2=PAUSE 3=SET
//   o_day_tick        pulse on 23:59:59 -> 00:00:00
//   o_err             pulse on a rejected start or set load
module matbi_watch_ctrl #(
    parameter int P_COUNT_BIT = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_clear,
    input  logic                   i_set_en,
    input  logic                   i_set_valid,
    input  logic [4:0]             i_set_hour,
    input  logic [5:0]             i_set_min,
    input  logic [5:0]             i_set_sec,
    input  logic [P_COUNT_BIT-1:0] i_freq_cfg,
    input  logic                   i_one_sec_tick,
    output logic                   o_run_en,
    output logic [P_COUNT_BIT-1:0] o_freq,
    output logic                   o_gen_reset,
    output logic [4:0]             o_hour,
    output logic [5:0]             o_min,
    output logic [5:0]             o_sec,
    output logic [1:0]             o_state,
    output logic                   o_day_tick,
    output logic                   o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_SET   = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [P_COUNT_BIT-1:0] freq_d;
    logic                   gen_reset_d;
    logic                   err_d;
    logic                   load_time;
    logic                   clear_time;
    logic                   tick_adv;
    logic                   set_ok;
    logic                   start_ok;

    assign set_ok   = (i_set_hour <= 5'd23) && (i_set_min <= 6'd59) && (i_set_sec <= 6'd59);
    assign start_ok = (i_freq_cfg != '0);
    // Ticks count only in RUN as currently registered, so the tick sampled
    // together with i_stop still advances the time.
    assign tick_adv = i_one_sec_tick && (state_q == S_RUN);

    always_comb begin
        state_d     = state_q;
        freq_d      = o_freq;
        gen_reset_d = 1'b0;
        err_d       = 1'b0;
        load_time   = 1'b0;
        clear_time  = 1'b0;
        if (i_clear) begin
            state_d     = S_IDLE;
            clear_time  = 1'b1;
            gen_reset_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        if (start_ok) begin
                            state_d     = S_RUN;
                            freq_d      = i_freq_cfg;
                            gen_reset_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (i_set_en) begin
                        state_d = S_SET;
                    end
                end
                S_RUN: begin
                    if (i_stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    // Resume keeps the generator phase and divide value.
                    if (i_start) begin
                        state_d = S_RUN;
                    end else if (i_set_en) begin
                        state_d = S_SET;
                    end
                end
                S_SET: begin
                    if (i_stop) begin
                        state_d = S_PAUSE;
                    end else if (i_start) begin
                        if (start_ok) begin
                            state_d     = S_RUN;
                            freq_d      = i_freq_cfg;
                            gen_reset_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (i_set_valid) begin
                        if (set_ok) begin
                            load_time = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            o_run_en    <= 1'b0;
            o_freq      <= '0;
            o_gen_reset <= 1'b1;
            o_err       <= 1'b0;
            o_day_tick  <= 1'b0;
            o_hour      <= '0;
            o_min       <= '0;
            o_sec       <= '0;
        end else begin
            state_q     <= state_d;
            // Registered from the next state so it never lags the state register.
            o_run_en    <= (state_d == S_RUN);
            o_freq      <= freq_d;
            o_gen_reset <= gen_reset_d;
            o_err       <= err_d;
            o_day_tick  <= 1'b0;
            if (clear_time) begin
                o_hour <= '0;
                o_min  <= '0;
                o_sec  <= '0;
            end else if (load_time) begin
                o_hour <= i_set_hour;
                o_min  <= i_set_min;
                o_sec  <= i_set_sec;
            end else if (tick_adv) begin
                if (o_sec == 6'd59) begin
                    o_sec <= '0;
                    if (o_min == 6'd59) begin
                        o_min <= '0;
                        if (o_hour == 5'd23) begin
                            o_hour     <= '0;
                            o_day_tick <= 1'b1;
                        end else begin
                            o_hour <= o_hour + 5'd1;
                        end
                    end else begin
                        o_min <= o_min + 6'd1;
                    end
                end else begin
                    o_sec <= o_sec + 6'd1;
                end
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_matbi_watch_ctrl.sv
// tb/tb_matbi_watch_ctrl.sv - self-checking bench for matbi_watch_ctrl
module tb_matbi_watch_ctrl;

    localparam int CB = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_set_en = 1'b0;
    logic          i_set_valid = 1'b0;
    logic [4:0]    i_set_hour = '0;
    logic [5:0]    i_set_min = '0;
    logic [5:0]    i_set_sec = '0;
    logic [CB-1:0] i_freq_cfg = '0;
    logic          i_one_sec_tick = 1'b0;
    logic          o_run_en;
    logic [CB-1:0] o_freq;
    logic          o_gen_reset;
    logic [4:0]    o_hour;
    logic [5:0]    o_min;
    logic [5:0]    o_sec;
    logic [1:0]    o_state;
    logic          o_day_tick;
    logic          o_err;

    matbi_watch_ctrl #(.P_COUNT_BIT(CB)) dut (
        .clk(clk), .reset(reset),
        .i_start(i_start), .i_stop(i_stop), .i_clear(i_clear),
        .i_set_en(i_set_en), .i_set_valid(i_set_valid),
        .i_set_hour(i_set_hour), .i_set_min(i_set_min), .i_set_sec(i_set_sec),
        .i_freq_cfg(i_freq_cfg), .i_one_sec_tick(i_one_sec_tick),
        .o_run_en(o_run_en), .o_freq(o_freq), .o_gen_reset(o_gen_reset),
        .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
        .o_state(o_state), .o_day_tick(o_day_tick), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       day;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   m_h = 0;
    int   m_m = 0;
    int   m_s = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_h = 0; m_m = 0; m_s = 0;
    endtask

    // Drive one tick; the expected time is queued when the tick is driven
    // and popped once the DUT has sampled it.
    task automatic tick(input bit counts);
        exp_t e;
        exp_t got;
        bit   day;
        day = 1'b0;
        if (counts) begin
            if (m_s == 59) begin
                m_s = 0;
                if (m_m == 59) begin
                    m_m = 0;
                    if (m_h == 23) begin m_h = 0; day = 1'b1; end
                    else m_h++;
                end else m_m++;
            end else m_s++;
        end
        e.h = 5'(m_h); e.m = 6'(m_m); e.s = 6'(m_s); e.day = day;
        exp_q.push_back(e);
        i_one_sec_tick = 1'b1;
        step();
        i_one_sec_tick = 1'b0;
        got = exp_q.pop_front();
        total++;
        if ({o_hour, o_min, o_sec, o_day_tick} !== {got.h, got.m, got.s, got.day})
            $display("FAIL tick_time got %0d:%0d:%0d day=%0b want %0d:%0d:%0d day=%0b",
                     o_hour, o_min, o_sec, o_day_tick, got.h, got.m, got.s, got.day);
        else passed++;
    endtask

    task automatic do_clear();
        i_clear = 1'b1; step(); i_clear = 1'b0;
        model_zero();
    endtask

    task automatic do_start(input int freq);
        i_freq_cfg = CB'(freq);
        i_start = 1'b1; step(); i_start = 1'b0;
    endtask

    // Enter SET from IDLE/PAUSE and present one load.
    task automatic do_set(input int h, input int m, input int s);
        i_set_en = 1'b1; step(); i_set_en = 1'b0;
        i_set_hour = 5'(h); i_set_min = 6'(m); i_set_sec = 6'(s);
        i_set_valid = 1'b1; step(); i_set_valid = 1'b0;
        if (h <= 23 && m <= 59 && s <= 59) begin
            m_h = h; m_m = m; m_s = s;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        total++;
        if ({o_state, o_run_en, o_gen_reset, o_err, o_day_tick} !== 6'b00_0_1_0_0)
            $display("FAIL reset_ctrl got st=%0d run=%0b gr=%0b err=%0b day=%0b want 0 0 1 0 0",
                     o_state, o_run_en, o_gen_reset, o_err, o_day_tick);
        else passed++;
        total++;
        if ({o_hour, o_min, o_sec} !== 17'd0 || o_freq !== '0)
            $display("FAIL reset_time got %0d:%0d:%0d freq=%0d want 0:0:0 freq=0",
                     o_hour, o_min, o_sec, o_freq);
        else passed++;
        reset = 1'b0; step();
        total++;
        if (o_gen_reset !== 1'b0)
            $display("FAIL reset_gr_release got %0b want 0", o_gen_reset);
        else passed++;
        model_zero();
    endtask

    task automatic test_start_count();
        do_start(5);
        total++;
        if ({o_state, o_run_en, o_gen_reset} !== 4'b01_1_1 || o_freq !== CB'(5))
            $display("FAIL start got st=%0d run=%0b gr=%0b freq=%0d want 1 1 1 5",
                     o_state, o_run_en, o_gen_reset, o_freq);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            repeat (4) step();
            total++;
            if (o_sec !== 6'(m_s) || o_gen_reset !== 1'b0)
                $display("FAIL idle_between_ticks got sec=%0d gr=%0b want sec=%0d gr=0",
                         o_sec, o_gen_reset, m_s);
            else passed++;
            tick(1'b1);
        end
    endtask

    task automatic test_rollover();
        do_clear();
        do_set(23, 59, 58);
        total++;
        if (o_state !== 2'd3 || {o_hour, o_min, o_sec} !== {5'd23, 6'd59, 6'd58})
            $display("FAIL set_load got st=%0d %0d:%0d:%0d want 3 23:59:58",
                     o_state, o_hour, o_min, o_sec);
        else passed++;
        do_start(5);
        tick(1'b1);
        tick(1'b1);
        step();
        total++;
        if (o_day_tick !== 1'b0)
            $display("FAIL day_tick_width got %0b want 0", o_day_tick);
        else passed++;
    endtask

    task automatic test_stop_pause();
        do_clear();
        do_set(0, 0, 7);
        do_start(5);
        i_stop = 1'b1;
        tick(1'b1);
        i_stop = 1'b0;
        total++;
        if (o_state !== 2'd2 || o_run_en !== 1'b0)
            $display("FAIL stop got st=%0d run=%0b want 2 0", o_state, o_run_en);
        else passed++;
        tick(1'b0);
        step();
        tick(1'b0);
        do_start(9);
        total++;
        if ({o_state, o_run_en, o_gen_reset} !== 4'b01_1_0 || o_freq !== CB'(5))
            $display("FAIL resume got st=%0d run=%0b gr=%0b freq=%0d want 1 1 0 5",
                     o_state, o_run_en, o_gen_reset, o_freq);
        else passed++;
        tick(1'b1);
    endtask

    task automatic test_errors();
        do_clear();
        do_set(1, 2, 3);
        i_set_hour = 5'd24; i_set_min = 6'd0; i_set_sec = 6'd0;
        i_set_valid = 1'b1; step(); i_set_valid = 1'b0;
        total++;
        if (o_err !== 1'b1 || {o_hour, o_min, o_sec} !== {5'd1, 6'd2, 6'd3})
            $display("FAIL set_bad_hour got err=%0b %0d:%0d:%0d want 1 1:2:3",
                     o_err, o_hour, o_min, o_sec);
        else passed++;
        i_set_hour = 5'd4; i_set_min = 6'd5; i_set_sec = 6'd60;
        i_set_valid = 1'b1; step(); i_set_valid = 1'b0;
        total++;
        if (o_err !== 1'b1 || {o_hour, o_min, o_sec} !== {5'd1, 6'd2, 6'd3})
            $display("FAIL set_bad_sec got err=%0b %0d:%0d:%0d want 1 1:2:3",
                     o_err, o_hour, o_min, o_sec);
        else passed++;
        step();
        total++;
        if (o_err !== 1'b0)
            $display("FAIL err_width got %0b want 0", o_err);
        else passed++;
        do_clear();
        do_start(0);
        total++;
        if (o_err !== 1'b1 || o_state !== 2'd0 || o_run_en !== 1'b0 || o_gen_reset !== 1'b0)
            $display("FAIL start_freq0 got err=%0b st=%0d run=%0b gr=%0b want 1 0 0 0",
                     o_err, o_state, o_run_en, o_gen_reset);
        else passed++;
    endtask

    task automatic test_clear_reset();
        do_clear();
        do_set(12, 34, 56);
        do_start(5);
        i_clear = 1'b1; i_stop = 1'b1; i_one_sec_tick = 1'b1;
        step();
        i_clear = 1'b0; i_stop = 1'b0; i_one_sec_tick = 1'b0;
        model_zero();
        total++;
        if (o_state !== 2'd0 || {o_hour, o_min, o_sec} !== 17'd0 || o_gen_reset !== 1'b1)
            $display("FAIL clear_stop got st=%0d %0d:%0d:%0d gr=%0b want 0 0:0:0 1",
                     o_state, o_hour, o_min, o_sec, o_gen_reset);
        else passed++;
        do_set(3, 4, 5);
        do_start(7);
        tick(1'b1);
        reset = 1'b1; step();
        total++;
        if ({o_state, o_run_en, o_gen_reset, o_err, o_day_tick} !== 6'b00_0_1_0_0 ||
            {o_hour, o_min, o_sec} !== 17'd0 || o_freq !== '0)
            $display("FAIL mid_reset got st=%0d run=%0b gr=%0b %0d:%0d:%0d freq=%0d want 0 0 1 0:0:0 0",
                     o_state, o_run_en, o_gen_reset, o_hour, o_min, o_sec, o_freq);
        else passed++;
        reset = 1'b0; step();
        model_zero();
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_start(1);
        for (int k = 0; k < 60; k++) tick(1'b1);
        total++;
        if ({o_hour, o_min, o_sec} !== {5'd0, 6'd1, 6'd0})
            $display("FAIL b2b_final got %0d:%0d:%0d want 0:1:0", o_hour, o_min, o_sec);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_start_count();
        test_rollover();
        test_stop_pause();
        test_errors();
        test_clear_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
